// File: rtl/rx_dmac.sv
// Receive-side DMA: drains the RX AXI-Stream into a circular DDR window through an
// AXI4 write master, one fixed-length INCR burst at a time, tracking window occupation.
module rx_dmac #(
    parameter int unsigned ADDR_W = 48,
    parameter int unsigned DATA_W = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write_enable,
    output logic                write_busy,
    input  logic [ADDR_W-1:0]   write_base_address,
    input  logic [31:0]         write_ddr_size,
    input  logic [8:0]          write_burst_len,
    input  logic [31:0]         write_burst_count,
    input  logic [DATA_W-1:0]   s_axis_rx_tdata,
    input  logic                s_axis_rx_tvalid,
    output logic                s_axis_rx_tready,
    input  logic                rx_fifo_has_burst,
    input  logic                rx_fifo_full,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [16:0]         write_access_size_bytes,
    input  logic                write_access_tick,
    output logic                write_access_tick_ack,
    output logic                write_burst_tick,
    output logic [31:0]         write_total_burst_count,
    output logic [31:0]         write_current_burst_address,
    output logic [1:0]          write_bresp,
    output logic                write_overflow_ins,
    output logic [7:0]          write_overflow_count,
    output logic [31:0]         write_ddr_occupation,
    output logic                write_ddr_full,
    output logic [2:0]          write_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        RESP  = 3'd4,
        NEXT  = 3'd5
    } state_t;

    state_t      state;
    logic [7:0]  beat_idx;
    logic [31:0] burst_cnt;
    logic [31:0] burst_bytes;
    logic [8:0]  len_m1;
    logic        w_beat;
    logic        resp_hs;
    logic        tick_take;
    logic [32:0] occ_plus_burst;
    logic [33:0] occ_sum;
    logic [33:0] occ_sub;
    logic [33:0] occ_diff;
    logic [ADDR_W:0] addr_inc;
    logic [ADDR_W:0] win_end;

    assign burst_bytes = {19'd0, write_burst_len, 4'd0};
    assign len_m1      = write_burst_len - 9'd1;

    // W channel is a straight pass-through of the stream while in DATA
    assign m_axi_wdata      = s_axis_rx_tdata;
    assign m_axi_wstrb      = '1;
    assign m_axi_wvalid     = (state == DATA) && s_axis_rx_tvalid;
    assign s_axis_rx_tready = (state == DATA) && m_axi_wready;
    assign m_axi_wlast      = (state == DATA) && ({1'b0, beat_idx} == len_m1);
    assign w_beat           = m_axi_wvalid && m_axi_wready;

    assign resp_hs   = (state == RESP) && m_axi_bvalid && m_axi_bready;
    assign tick_take = write_access_tick && !write_access_tick_ack;

    assign occ_plus_burst = {1'b0, write_ddr_occupation} + {1'b0, burst_bytes};
    assign write_ddr_full = occ_plus_burst > {1'b0, write_ddr_size};

    assign addr_inc = {1'b0, m_axi_awaddr} + {{(ADDR_W-31){1'b0}}, burst_bytes};
    assign win_end  = {1'b0, write_base_address} + {{(ADDR_W-31){1'b0}}, write_ddr_size};

    assign write_busy  = (state != IDLE);
    assign write_state = state;

    // A burst add and a host drain in the same cycle net out; the result clamps at zero
    always_comb begin
        occ_sum = {2'b00, write_ddr_occupation};
        if (resp_hs)
            occ_sum = occ_sum + {2'b00, burst_bytes};
        occ_sub = '0;
        if (tick_take)
            occ_sub = {17'd0, write_access_size_bytes};
        occ_diff = (occ_sum > occ_sub) ? (occ_sum - occ_sub) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                       <= IDLE;
            beat_idx                    <= '0;
            burst_cnt                   <= '0;
            m_axi_awaddr                <= write_base_address;
            m_axi_awlen                 <= '0;
            m_axi_awvalid               <= 1'b0;
            m_axi_bready                <= 1'b0;
            write_access_tick_ack       <= 1'b0;
            write_burst_tick            <= 1'b0;
            write_total_burst_count     <= '0;
            write_current_burst_address <= '0;
            write_bresp                 <= '0;
            write_overflow_ins          <= 1'b0;
            write_overflow_count        <= '0;
            write_ddr_occupation        <= '0;
        end else begin
            write_burst_tick      <= 1'b0;
            write_overflow_ins    <= 1'b0;
            write_access_tick_ack <= write_access_tick;
            write_ddr_occupation  <= occ_diff[31:0];

            case (state)
                IDLE: begin
                    m_axi_awaddr <= write_base_address;
                    beat_idx     <= '0;
                    burst_cnt    <= '0;
                    if (write_enable) begin
                        state <= CHECK;
                    end else begin
                        write_total_burst_count <= '0;
                        write_overflow_count    <= '0;
                    end
                end
                CHECK: begin
                    if (rx_fifo_has_burst && !write_ddr_full) begin
                        m_axi_awvalid               <= 1'b1;
                        m_axi_awlen                 <= len_m1[7:0];
                        write_current_burst_address <= m_axi_awaddr[31:0];
                        state                       <= ADDR;
                    end else if (rx_fifo_full && write_ddr_full) begin
                        write_overflow_ins <= 1'b1;
                        if (write_overflow_count != 8'hFF)
                            write_overflow_count <= write_overflow_count + 8'd1;
                    end
                end
                ADDR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (w_beat) begin
                        if (m_axi_wlast) begin
                            beat_idx     <= '0;
                            m_axi_bready <= 1'b1;
                            state        <= RESP;
                        end else begin
                            beat_idx <= beat_idx + 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready            <= 1'b0;
                        write_bresp             <= m_axi_bresp;
                        write_burst_tick        <= 1'b1;
                        burst_cnt               <= burst_cnt + 32'd1;
                        write_total_burst_count <= write_total_burst_count + 32'd1;
                        m_axi_awaddr            <= (addr_inc >= win_end) ? write_base_address
                                                                         : addr_inc[ADDR_W-1:0];
                        state                   <= NEXT;
                    end
                end
                NEXT: begin
                    if (write_enable && !write_bresp[1] &&
                        (write_burst_count == 32'd0 || burst_cnt < write_burst_count))
                        state <= CHECK;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_dmac.sv
// Self-checking bench for rx_dmac: a behavioural window/stream model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rx_dmac;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         write_enable = 1'b0;
    logic         write_busy;
    logic [47:0]  write_base_address = '0;
    logic [31:0]  write_ddr_size = 32'd4096;
    logic [8:0]   write_burst_len = 9'd16;
    logic [31:0]  write_burst_count = '0;
    logic [127:0] s_axis_rx_tdata = '0;
    logic         s_axis_rx_tvalid = 1'b0;
    logic         s_axis_rx_tready;
    logic         rx_fifo_has_burst = 1'b1;
    logic         rx_fifo_full = 1'b0;
    logic [47:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic         m_axi_awvalid;
    logic         m_axi_awready = 1'b1;
    logic [127:0] m_axi_wdata;
    logic [15:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready = 1'b1;
    logic [1:0]   m_axi_bresp = '0;
    logic         m_axi_bvalid = 1'b0;
    logic         m_axi_bready;
    logic [16:0]  write_access_size_bytes = 17'd256;
    logic         write_access_tick = 1'b0;
    logic         write_access_tick_ack;
    logic         write_burst_tick;
    logic [31:0]  write_total_burst_count;
    logic [31:0]  write_current_burst_address;
    logic [1:0]   write_bresp;
    logic         write_overflow_ins;
    logic [7:0]   write_overflow_count;
    logic [31:0]  write_ddr_occupation;
    logic         write_ddr_full;
    logic [2:0]   write_state;

    always #5 clk = ~clk;

    rx_dmac #(.ADDR_W(48), .DATA_W(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .write_enable(write_enable), .write_busy(write_busy),
        .write_base_address(write_base_address), .write_ddr_size(write_ddr_size),
        .write_burst_len(write_burst_len), .write_burst_count(write_burst_count),
        .s_axis_rx_tdata(s_axis_rx_tdata), .s_axis_rx_tvalid(s_axis_rx_tvalid),
        .s_axis_rx_tready(s_axis_rx_tready),
        .rx_fifo_has_burst(rx_fifo_has_burst), .rx_fifo_full(rx_fifo_full),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .write_access_size_bytes(write_access_size_bytes),
        .write_access_tick(write_access_tick), .write_access_tick_ack(write_access_tick_ack),
        .write_burst_tick(write_burst_tick), .write_total_burst_count(write_total_burst_count),
        .write_current_burst_address(write_current_burst_address),
        .write_bresp(write_bresp), .write_overflow_ins(write_overflow_ins),
        .write_overflow_count(write_overflow_count),
        .write_ddr_occupation(write_ddr_occupation), .write_ddr_full(write_ddr_full),
        .write_state(write_state)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mkdata(input int unsigned i);
        logic [31:0] v;
        v = i;
        return {v ^ 32'hDEAD_0000, ~v, v + 32'h0000_1000, v};
    endfunction

    // Stimulus knobs shared with the background drivers
    logic        stall_en = 1'b0;
    int unsigned tick_mode = 0;
    int unsigned slverr_at = 32'hFFFF_FFFF;
    int unsigned src_idx = 0;
    int unsigned b_num = 0;

    // Stream source: tdata carries its own sequence number, advanced on each accepted beat
    initial begin
        logic hs;
        s_axis_rx_tdata = mkdata(0);
        forever begin
            @(negedge clk);
            hs = s_axis_rx_tvalid && s_axis_rx_tready;
            @(posedge clk);
            #1;
            if (hs) src_idx++;
            s_axis_rx_tdata  = mkdata(src_idx);
            s_axis_rx_tvalid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_axi_wready     = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_axi_awready    = stall_en ? ($urandom_range(0, 1) != 0) : 1'b1;
        end
    end

    // Write-response slave: answers bready one cycle later, SLVERR on a chosen burst
    initial begin
        logic hsb, rdy;
        forever begin
            @(negedge clk);
            hsb = m_axi_bvalid && m_axi_bready;
            rdy = m_axi_bready;
            @(posedge clk);
            #1;
            if (hsb) begin
                m_axi_bvalid = 1'b0;
                b_num++;
            end else if (rdy && !m_axi_bvalid) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (b_num == slverr_at) ? 2'b10 : 2'b00;
            end
        end
    end

    // Host drain ticks: mode 1 = one tick after every burst, mode 2 = tick coinciding with bvalid of burst 2
    initial begin
        int unsigned n;
        forever begin
            @(negedge clk);
            if ((tick_mode == 1 && write_burst_tick) ||
                (tick_mode == 2 && m_axi_bready && !m_axi_bvalid && write_total_burst_count == 1)) begin
                n = (tick_mode == 1) ? 1 : 3;
                @(posedge clk);
                #1 write_access_tick = 1'b1;
                repeat (n) @(posedge clk);
                #1 write_access_tick = 1'b0;
            end
        end
    end

    // Behavioural model: window occupation, next burst address, stream order, handshake echoes
    longint      exp_occ = 0;
    logic        exp_ack = 1'b0;
    logic        exp_tick = 1'b0;
    logic        tick_prev = 1'b0;
    logic [47:0] exp_addr = '0;
    int unsigned exp_idx = 0;
    int unsigned beat = 0;
    int unsigned wlast_cnt = 0;
    logic [47:0] aw_log[$];

    always @(negedge clk) begin
        longint bb, na;
        bb = longint'(write_burst_len) * 16;
        if (!rst_n) begin
            exp_occ   = 0;
            exp_ack   = 1'b0;
            exp_tick  = 1'b0;
            tick_prev = 1'b0;
            beat      = 0;
            exp_addr  = write_base_address;
        end else begin
            chk("occupation", write_ddr_occupation, exp_occ);
            chk("ddr_full", write_ddr_full, (exp_occ + bb) > longint'(write_ddr_size));
            chk("tick_ack", write_access_tick_ack, exp_ack);
            chk("burst_tick", write_burst_tick, exp_tick);
            if (m_axi_awvalid && m_axi_wvalid) chk("aw_w_overlap", 1, 0);
            if (m_axi_awvalid && m_axi_awready) begin
                chk("awaddr", m_axi_awaddr, exp_addr);
                chk("awlen", m_axi_awlen, write_burst_len - 9'd1);
                chk("cur_burst_addr", write_current_burst_address, exp_addr[31:0]);
                aw_log.push_back(m_axi_awaddr);
            end
            if (m_axi_wvalid) begin
                chk("wvalid_needs_tvalid", s_axis_rx_tvalid, 1);
                chk("tready_eq_wready", s_axis_rx_tready, m_axi_wready);
                chk("wstrb", m_axi_wstrb, 16'hFFFF);
            end
            if (m_axi_wvalid && m_axi_wready) begin
                chk("wdata_order", m_axi_wdata, mkdata(exp_idx));
                chk("wlast", m_axi_wlast, beat == write_burst_len - 1);
                exp_idx++;
                if (beat == write_burst_len - 1) begin
                    beat = 0;
                    wlast_cnt++;
                end else begin
                    beat++;
                end
            end
            exp_tick = m_axi_bvalid && m_axi_bready;
            if (m_axi_bvalid && m_axi_bready) begin
                exp_occ += bb;
                na = longint'(exp_addr) + bb;
                if (na >= longint'(write_base_address) + longint'(write_ddr_size))
                    exp_addr = write_base_address;
                else
                    exp_addr = 48'(na);
            end
            if (write_access_tick && !tick_prev)
                exp_occ = (exp_occ > longint'(write_access_size_bytes)) ?
                          exp_occ - longint'(write_access_size_bytes) : 0;
            tick_prev = write_access_tick;
            exp_ack   = write_access_tick;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        aw_log.delete();
        wlast_cnt = 0;
    endtask

    task automatic setup(input logic [47:0] base, input logic [31:0] size,
                         input logic [31:0] count, input logic [16:0] access);
        write_base_address      = base;
        write_ddr_size          = size;
        write_burst_len         = 9'd16;
        write_burst_count       = count;
        write_access_size_bytes = access;
    endtask

    task automatic wait_total(input int unsigned n, input int unsigned budget);
        int unsigned k;
        k = 0;
        while (write_total_burst_count < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (write_total_burst_count < n) chk("timeout_total", write_total_burst_count, n);
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (write_busy && k < budget);
        if (write_busy) chk("timeout_idle", write_busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned idx0;

        // 1: four bursts, host idle
        setup(48'hAB_0000_1000, 32'd4096, 32'd4, 17'd256);
        do_reset();
        @(negedge clk);
        chk("reset_state", write_state, 0);
        chk("reset_awaddr", m_axi_awaddr, 48'hAB_0000_1000);
        chk("reset_occ", write_ddr_occupation, 0);
        chk("reset_awvalid", m_axi_awvalid, 0);
        chk("reset_busy", write_busy, 0);
        write_enable = 1'b1;
        wait_total(4, 2000);
        chk("t1_total", write_total_burst_count, 4);
        chk("t1_occ", write_ddr_occupation, 1024);
        @(negedge clk);
        chk("t1_idle_after_count", write_state, 0);
        write_enable = 1'b0;
        chk("t1_aw_count", aw_log.size(), 4);
        if (aw_log.size() == 4) begin
            chk("t1_aw0", aw_log[0], 48'hAB_0000_1000);
            chk("t1_aw1", aw_log[1], 48'hAB_0000_1100);
            chk("t1_aw2", aw_log[2], 48'hAB_0000_1200);
            chk("t1_aw3", aw_log[3], 48'hAB_0000_1300);
        end
        chk("t1_wlast_count", wlast_cnt, 4);

        // 2: random stalls on stream, W and AW
        setup(48'h0000_0002_0000, 32'd8192, 32'd3, 17'd256);
        do_reset();
        idx0 = exp_idx;
        stall_en = 1'b1;
        write_enable = 1'b1;
        wait_total(3, 3000);
        write_enable = 1'b0;
        wait_idle(500);
        stall_en = 1'b0;
        chk("t2_beats", exp_idx - idx0, 48);
        chk("t2_src_beats", src_idx, exp_idx);
        chk("t2_wlast_count", wlast_cnt, 3);

        // 3: 512-byte window, host drains 256 B after each burst, runs until enable drops
        setup(48'h0000_0010_0000, 32'd512, 32'd0, 17'd256);
        do_reset();
        tick_mode = 1;
        write_enable = 1'b1;
        wait_total(4, 3000);
        write_enable = 1'b0;
        wait_idle(500);
        repeat (4) @(negedge clk);
        tick_mode = 0;
        chk("t3_occ_drained", write_ddr_occupation, 0);
        if (aw_log.size() >= 4) begin
            chk("t3_aw0", aw_log[0], 48'h0000_0010_0000);
            chk("t3_aw1", aw_log[1], 48'h0000_0010_0100);
            chk("t3_aw2", aw_log[2], 48'h0000_0010_0000);
            chk("t3_aw3", aw_log[3], 48'h0000_0010_0100);
        end else begin
            chk("t3_aw_count", aw_log.size(), 4);
        end

        // 4: window fills, overflow counting and saturation
        setup(48'h0000_0020_0000, 32'd512, 32'd0, 17'd256);
        do_reset();
        write_enable = 1'b1;
        wait_total(2, 2000);
        repeat (5) @(negedge clk);
        chk("t4_hold_check", write_state, 1);
        chk("t4_full", write_ddr_full, 1);
        chk("t4_occ", write_ddr_occupation, 512);
        chk("t4_ovf_zero", write_overflow_count, 0);
        rx_fifo_full = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_ovf_3", write_overflow_count, 3);
        chk("t4_ovf_ins", write_overflow_ins, 1);
        repeat (300) @(negedge clk);
        chk("t4_ovf_sat", write_overflow_count, 255);
        chk("t4_ovf_ins_sat", write_overflow_ins, 1);
        rx_fifo_full = 1'b0;
        write_enable = 1'b0;

        // 5: SLVERR on second of four bursts stops the run
        setup(48'h0000_0030_0000, 32'd4096, 32'd4, 17'd256);
        do_reset();
        slverr_at = b_num + 1;
        write_enable = 1'b1;
        wait_total(2, 2000);
        @(negedge clk);
        chk("t5_bresp", write_bresp, 2'b10);
        chk("t5_total", write_total_burst_count, 2);
        chk("t5_idle", write_state, 0);
        write_enable = 1'b0;
        slverr_at = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);

        // 6: access tick coincides with bvalid
        setup(48'h0000_0040_0000, 32'd4096, 32'd2, 17'd256);
        do_reset();
        tick_mode = 2;
        write_enable = 1'b1;
        wait_total(1, 2000);
        chk("t6_occ_before", write_ddr_occupation, 256);
        wait_total(2, 2000);
        chk("t6_occ_net", write_ddr_occupation, 256);
        chk("t6_ack_high", write_access_tick_ack, 1);
        write_enable = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_ack_low", write_access_tick_ack, 0);
        tick_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_dmac.md
# rx_dmac

Receive-side DMA controller that drains the 128-bit RX AXI-Stream into DDR through an AXI4 write master (AW/W/B), one fixed-length INCR burst at a time. It treats a DDR window as a circular pseudo-FIFO, tracks its occupation against host drain ticks, and reports burst completions, overflow events and write responses. It sits between the RX sample FIFO and the DDR interconnect, mirroring the TX read DMA on the other side of DDR.

## Interface
- ADDR_W, 48, AXI address width.
- DATA_W, 128, data width; one beat is 16 bytes.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- write_enable  in  1  run request; sampled in IDLE and after each burst.
- write_busy  out  1  state != IDLE.
- write_base_address  in  48  window base; 4 KiB aligned.
- write_ddr_size  in  32  window size in bytes; multiple of burst bytes.
- write_burst_len  in  9  beats per burst, 1..256; burst bytes = len*16.
- write_burst_count  in  32  bursts per run; 0 = run until write_enable drops.
- s_axis_rx_tdata / tvalid / tready  in/in/out  128/1/1  RX stream.
- rx_fifo_has_burst  in  1  upstream FIFO holds >= write_burst_len beats.
- rx_fifo_full  in  1  upstream FIFO full.
- m_axi_awaddr / awlen / awvalid / awready  out/out/out/in  48/8/1/1; awlen = write_burst_len-1, INCR, size 16 B.
- m_axi_wdata / wstrb / wlast / wvalid / wready  out/out/out/out/in  128/16/1/1/1; wstrb = all ones.
- m_axi_bresp / bvalid / bready  in/in/out  2/1/1.
- write_access_size_bytes  in  17  bytes consumed by host per access tick.
- write_access_tick / write_access_tick_ack  in/out  1/1  level handshake: ack rises one cycle after tick is seen high, falls one cycle after tick falls.
- write_burst_tick  out  1  one-cycle pulse per completed burst.
- write_total_burst_count  out  32  bursts completed this run.
- write_current_burst_address  out  32  low 32 bits of the last burst's awaddr.
- write_bresp  out  2  last captured BRESP.
- write_overflow_ins / write_overflow_count  out  1/8  overflow pulse / saturating count.
- write_ddr_occupation  out  32  unread bytes in window.
- write_ddr_full  out  1  occupation + burst bytes > write_ddr_size.
- write_state  out  3  FSM state.

## Operation
- States: 0 IDLE, 1 CHECK, 2 ADDR, 3 DATA, 4 RESP, 5 NEXT.
- IDLE: awaddr <= base, beat index, burst counter and pulses <= 0; write_enable -> CHECK; otherwise also clear total and overflow counts.
- CHECK: rx_fifo_has_burst && !write_ddr_full -> awvalid <= 1, latch current_burst_address, go ADDR. Else stay; when rx_fifo_full && write_ddr_full, pulse overflow_ins and increment overflow_count (saturates at 255).
- ADDR: hold awvalid until awready; on handshake drop awvalid and go DATA.
- DATA: wvalid = s_axis_rx_tvalid, s_axis_rx_tready = m_axi_wready, wdata = tdata, wlast = (beat index == len-1). On each beat increment the 8-bit index; beat with wlast -> RESP. Outside DATA, wvalid = tready = 0.
- RESP: bready = 1; on bvalid capture bresp, pulse burst_tick, increment burst and total counts, add burst bytes to occupation, advance awaddr by burst bytes, wrapping to base when the next address >= base + ddr_size; go NEXT.
- NEXT: write_enable && !bresp[1] && (burst_count == 0 || counter < burst_count) -> CHECK, else IDLE.
- Occupation: a burst add and an access-tick subtract in the same cycle both apply (net change). Subtraction clamps at 0.
- write_enable falling mid-burst does not abort: the burst completes through RESP, then the block returns to IDLE.

## Timing
- Reset: all outputs 0, state IDLE, awaddr = base, occupation 0.
- CHECK to awvalid high: 1 cycle. AW handshake to first wvalid eligibility: 1 cycle.
- W is combinational pass-through: zero added latency; throughput is one beat per cycle when tvalid && wready.
- bvalid to burst_tick: 1 cycle. NEXT to CHECK: 1 cycle. Minimum overhead is 4 cycles per burst outside DATA.
- No AW/W overlap and one outstanding transaction at a time.
- rst_n low mid-burst forces IDLE on the next edge. The interconnect must be reset together with this block.

## Test plan
- len=16, count=4, size=4096, stream always valid, host idle -> 4 AW at base+0/256/512/768, awlen=15, 16 beats each, wlast on beat 16, occupation=1024, 4 burst_tick pulses, return to IDLE.
- Random tvalid/wready stalls, len=16 -> data order preserved, no beat lost or duplicated, wlast only on the 16th accepted beat.
- size=512, len=16, count=0, host ticks 256 B after each burst -> awaddr wraps base, +256, base; occupation oscillates 256/0; runs until enable drops.
- Host idle, size=512 -> after 2 bursts ddr_full=1, FSM holds in CHECK; rx_fifo_full=1 -> overflow_count increments per cycle and saturates at 255.
- bresp=SLVERR (2'b10) on burst 2 of 4 -> write_bresp=2, FSM goes IDLE after burst 2, total=2.
- Access tick and bvalid in the same cycle (256 B each, occupation 256) -> occupation stays 256; ack high for exactly one tick cycle plus one, then low one cycle after tick falls.
